uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 107 ++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with 2-of-3 majority voting, optional parity
// and stop-bit checking; one-cycle result pulses are registered one clock after the stop decision.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  busy
);
    localparam int CW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, next_state;
    logic [CW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [1:0]            samp;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_en_q, par_typ_q, par_bad;
    logic                  wrap, decide, maj, frame_done, exp_par;

    assign wrap    = (edge_cnt == CW'(PRESCALE - 1));
    assign decide  = (edge_cnt == CW'(PRESCALE / 2 + 1));
    // samp[0]/samp[1] hold the two earlier samples; the third is the live line on the decision cycle
    assign maj     = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);
    assign exp_par = par_typ_q ? ~(^shift) : (^shift);
    assign busy    = (state != IDLE);

    always_comb begin
        next_state = state;
        frame_done = 1'b0;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START: begin
                if (decide && maj)  next_state = IDLE;
                else if (wrap)      next_state = DATA;
            end
            DATA: begin
                if (wrap && bit_cnt == BW'(DATA_WIDTH - 1))
                    next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: if (wrap) next_state = STOP;
            STOP: begin
                if (decide) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shift      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            state <= next_state;

            // the cycle that first sees the start edge is edge 0, so the counter leaves IDLE at 1
            if (state == IDLE)
                edge_cnt <= RX_IN ? '0 : CW'(1);
            else if (next_state == IDLE || wrap)
                edge_cnt <= '0;
            else
                edge_cnt <= edge_cnt + CW'(1);

            if (state == IDLE && !RX_IN) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_bad   <= 1'b0;
                bit_cnt   <= '0;
            end

            if (edge_cnt == CW'(PRESCALE / 2 - 1)) samp[0] <= RX_IN;
            if (edge_cnt == CW'(PRESCALE / 2))     samp[1] <= RX_IN;

            if (state == DATA && decide) shift   <= {maj, shift[DATA_WIDTH-1:1]};
            if (state == DATA && wrap)   bit_cnt <= bit_cnt + BW'(1);
            if (state == PARITY && decide) par_bad <= (maj != exp_par);

            Data_Valid <= frame_done & maj & ~par_bad;
            Par_Err    <= frame_done & par_bad;
            Stp_Err    <= frame_done & ~maj;
            if (frame_done && maj && !par_bad) P_DATA <= shift;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx: frames push expected results,
// a monitor records every output pulse, each test task pops and compares.
module tb_uart_rx;
    localparam int DW = 8;
    localparam int PS = 8;

    logic          CLK = 1'b0;
    logic          RST, RX_IN, PAR_EN, PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, Par_Err, Stp_Err, busy;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_Err(Par_Err),
        .Stp_Err(Stp_Err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        int          cyc;
        logic [DW-1:0] data;
        logic        dv;
        logic        pe;
        logic        se;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          obs_q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] last_good = '0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK)
        if (Data_Valid || Par_Err || Stp_Err)
            obs_q.push_back({cyc, P_DATA, Data_Valid, Par_Err, Stp_Err});

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        RX_IN = v;
        step(PS);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        step(n);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic sbit, input logic flip);
        rec_t e;
        logic mism;
        int   nb;
        mism  = pen && (pbit !== (ptyp ? ~(^d) : (^d)));
        nb    = pen ? DW + 2 : DW + 1;
        e.cyc = cyc + nb * PS + PS / 2 + 2;
        e.dv  = sbit && !mism;
        e.pe  = mism;
        e.se  = !sbit;
        if (e.dv) last_good = d;
        e.data = last_good;
        exp_q.push_back(e);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        drive_bit(1'b0);
        if (flip) begin
            PAR_EN  = !pen;
            PAR_TYP = !ptyp;
        end
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
    endtask

    task automatic test_reset;
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        step(2);
        n_cmp++; if (P_DATA !== '0)     begin n_bad++; $display("FAIL reset_p_data: got %h expected 00", P_DATA); end
        n_cmp++; if (Data_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b expected 0", Data_Valid); end
        n_cmp++; if (Par_Err !== 1'b0)  begin n_bad++; $display("FAIL reset_par_err: got %b expected 0", Par_Err); end
        n_cmp++; if (Stp_Err !== 1'b0)  begin n_bad++; $display("FAIL reset_stp_err: got %b expected 0", Stp_Err); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        RST = 1'b0;
        idle(4);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        RST = 1'b1;
        RX_IN = 1'b1;
        step(1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midframe_reset_busy: got %b expected 0", busy); end
        RST = 1'b0;
        idle(12 * PS);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midframe_reset_pulses: got %0d pulses expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_no_parity;
        rec_t e, o;
        send_frame(8'hBB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2 * PS);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL no_parity_frame: got cyc=%0d data=%h dv/pe/se=%b%b%b expected cyc=%0d data=%h dv/pe/se=%b%b%b", o.cyc, o.data, o.dv, o.pe, o.se, e.cyc, e.data, e.dv, e.pe, e.se); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL no_parity_extra: got %0d extra pulses expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_parity;
        rec_t e, o;
        send_frame(8'hBA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2 * PS);
        send_frame(8'h93, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2 * PS);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL parity_frame: got cyc=%0d data=%h dv/pe/se=%b%b%b expected cyc=%0d data=%h dv/pe/se=%b%b%b", o.cyc, o.data, o.dv, o.pe, o.se, e.cyc, e.data, e.dv, e.pe, e.se); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL parity_extra: got %0d extra pulses expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_parity_error;
        rec_t e, o;
        send_frame(8'h9B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2 * PS);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL parity_error_frame: got cyc=%0d data=%h dv/pe/se=%b%b%b expected cyc=%0d data=%h dv/pe/se=%b%b%b", o.cyc, o.data, o.dv, o.pe, o.se, e.cyc, e.data, e.dv, e.pe, e.se); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL parity_error_extra: got %0d extra pulses expected 0", obs_q.size()); end
        n_cmp++; if (P_DATA !== 8'h93) begin n_bad++; $display("FAIL parity_error_hold: got %h expected 93", P_DATA); end
        obs_q.delete();
    endtask

    task automatic test_stop_error;
        rec_t e, o;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3 * PS);
        send_frame(8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2 * PS);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL stop_error_frame: got cyc=%0d data=%h dv/pe/se=%b%b%b expected cyc=%0d data=%h dv/pe/se=%b%b%b", o.cyc, o.data, o.dv, o.pe, o.se, e.cyc, e.data, e.dv, e.pe, e.se); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL stop_error_extra: got %0d extra pulses expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_glitch;
        int t0;
        t0 = cyc;
        RX_IN = 1'b0;
        step(1);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
        step(1);
        RX_IN = 1'b1;
        for (int i = 0; i < 4 * PS && cyc < t0 + PS / 2 + 3; i++) step(1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_fall: got %b at cyc %0d expected 0", busy, cyc - t0); end
        idle(12 * PS);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d pulses expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_back_to_back;
        rec_t e, o;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2 * PS);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front(); else o = '0;
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL back_to_back_frame: got cyc=%0d data=%h dv/pe/se=%b%b%b expected cyc=%0d data=%h dv/pe/se=%b%b%b", o.cyc, o.data, o.dv, o.pe, o.se, e.cyc, e.data, e.dv, e.pe, e.se); end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL back_to_back_extra: got %0d extra pulses expected 0", obs_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL back_to_back_busy: got %b expected 0", busy); end
        obs_q.delete();
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset;
        test_no_parity;
        test_parity;
        test_parity_error;
        test_stop_error;
        test_glitch;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
